// File: rtl/seg_digit_scanner.sv
// Four-digit BCD scanner: time-multiplexes a held value onto one shared digit bus
// with active-low anodes. New values are swapped in only at a frame boundary.
module seg_digit_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        blank_lz,
  output logic [3:0]  digit_out,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic [15:0]      active;
  logic [15:0]      pending;
  logic [15:0]      active_next;
  logic             pend_vld;
  logic             tick;
  logic             frame_bnd;
  logic             blank_now;

  // Slot k>0 is a leading zero when digit k and every digit above it are zero.
  function automatic logic blank_slot(input logic [15:0] v, input logic [1:0] k);
    logic z;
    z = 1'b1;
    for (int j = 1; j < 4; j++) begin
      if (j >= int'(k) && v[4*j +: 4] != 4'h0) z = 1'b0;
    end
    return (k != 2'd0) && z;
  endfunction

  always_comb begin
    tick      = (div == DIV_LAST);
    frame_bnd = tick && (idx == 2'd3);
    idx_next  = idx;
    if (tick) idx_next = idx + 2'd1;
    active_next = active;
    if (frame_bnd) begin
      if (load)          active_next = data_in;
      else if (pend_vld) active_next = pending;
    end
    blank_now = blank_lz && blank_slot(active_next, idx_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div        <= '0;
      idx        <= 2'd3;
      active     <= 16'h0;
      pending    <= 16'h0;
      pend_vld   <= 1'b0;
      digit_out  <= 4'h0;
      an         <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      div        <= tick ? '0 : div + 1'b1;
      idx        <= idx_next;
      active     <= active_next;
      frame_done <= frame_bnd;
      // A load on the boundary edge goes straight to active, so pending is left alone.
      if (frame_bnd) begin
        pend_vld <= 1'b0;
      end else if (load) begin
        pending  <= data_in;
        pend_vld <= 1'b1;
      end
      if (tick) begin
        digit_out <= active_next[{idx_next, 2'b00} +: 4];
        an        <= blank_now ? 4'b1111 : ~(4'b0001 << idx_next);
      end
    end
  end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed bench for seg_digit_scanner with REFRESH_DIV=4: slot-by-slot table
// plus hand-written sequences for reset, boundary loads and back-to-back loads.
module tb_seg_digit_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        blank_lz;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  seg_digit_scanner #(.REFRESH_DIV(4), .DIV_W(2)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .blank_lz(blank_lz),
    .digit_out(digit_out), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [15:0] data;
    logic        blank;
    logic [3:0]  exp_an;
    logic [3:0]  exp_d;
    logic        exp_fd;
  } slot_vec_t;

  slot_vec_t vecs[22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] e_an,
                       input logic [3:0] e_d, input logic e_fd);
    n_tests++;
    if (an !== e_an || digit_out !== e_d || frame_done !== e_fd) begin
      n_fail++;
      $display("FAIL %s: an=%b digit=%h fd=%b, expected an=%b digit=%h fd=%b",
               name, an, digit_out, frame_done, e_an, e_d, e_fd);
    end
  endtask

  // Releases reset (optionally loading in the first cycle) and walks to slot 1.
  task automatic reset_seq(input string tag, input logic do_load, input logic [15:0] val);
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (do_load) begin
      load    = 1'b1;
      data_in = val;
    end
    check({tag, "_rel"}, 4'b1111, 4'h0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      load = 1'b0;
      check($sformatf("%s_pre%0d", tag, i), 4'b1111, 4'h0, 1'b0);
    end
    step();
    check({tag, "_slot0"}, 4'b1110, do_load ? val[3:0] : 4'h0, 1'b1);
    step();
    check({tag, "_fd_once"}, 4'b1110, do_load ? val[3:0] : 4'h0, 1'b0);
    repeat (3) step();
    check({tag, "_slot1"}, 4'b1101, do_load ? val[7:4] : 4'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = 16'h0; blank_lz = 1'b0;

    //          ld    data     blank an       d     fd
    vecs[0]  = '{1'b0, 16'h0,    1'b0, 4'b1011, 4'h2, 1'b0};
    vecs[1]  = '{1'b0, 16'h0,    1'b0, 4'b0111, 4'h1, 1'b0};
    vecs[2]  = '{1'b0, 16'h0,    1'b0, 4'b1110, 4'h4, 1'b1};
    vecs[3]  = '{1'b1, 16'h0070, 1'b1, 4'b1101, 4'h3, 1'b0};
    vecs[4]  = '{1'b0, 16'h0,    1'b1, 4'b1011, 4'h2, 1'b0};
    vecs[5]  = '{1'b0, 16'h0,    1'b1, 4'b0111, 4'h1, 1'b0};
    vecs[6]  = '{1'b0, 16'h0,    1'b1, 4'b1110, 4'h0, 1'b1};
    vecs[7]  = '{1'b0, 16'h0,    1'b1, 4'b1101, 4'h7, 1'b0};
    vecs[8]  = '{1'b0, 16'h0,    1'b1, 4'b1111, 4'h0, 1'b0};
    vecs[9]  = '{1'b0, 16'h0,    1'b1, 4'b1111, 4'h0, 1'b0};
    vecs[10] = '{1'b0, 16'h0,    1'b0, 4'b1110, 4'h0, 1'b1};
    vecs[11] = '{1'b0, 16'h0,    1'b0, 4'b1101, 4'h7, 1'b0};
    vecs[12] = '{1'b0, 16'h0,    1'b0, 4'b1011, 4'h0, 1'b0};
    vecs[13] = '{1'b0, 16'h0,    1'b0, 4'b0111, 4'h0, 1'b0};
    vecs[14] = '{1'b1, 16'h1234, 1'b0, 4'b1110, 4'h4, 1'b1};
    vecs[15] = '{1'b0, 16'h0,    1'b0, 4'b1101, 4'h3, 1'b0};
    vecs[16] = '{1'b1, 16'h5678, 1'b0, 4'b1011, 4'h2, 1'b0};
    vecs[17] = '{1'b0, 16'h0,    1'b0, 4'b0111, 4'h1, 1'b0};
    vecs[18] = '{1'b0, 16'h0,    1'b0, 4'b1110, 4'h8, 1'b1};
    vecs[19] = '{1'b0, 16'h0,    1'b0, 4'b1101, 4'h7, 1'b0};
    vecs[20] = '{1'b0, 16'h0,    1'b0, 4'b1011, 4'h6, 1'b0};
    vecs[21] = '{1'b0, 16'h0,    1'b0, 4'b0111, 4'h5, 1'b0};

    #2;
    check("reset_async", 4'b1111, 4'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    reset_seq("rst1", 1'b0, 16'h0);

    rst = 1'b1;
    @(posedge clk);
    reset_seq("load1234", 1'b1, 16'h1234);

    // Each record spans one slot: load (if any) lands on the first edge, check after the tick.
    foreach (vecs[i]) begin
      blank_lz = vecs[i].blank;
      if (vecs[i].ld) begin
        load    = 1'b1;
        data_in = vecs[i].data;
      end
      step();
      load = 1'b0;
      repeat (3) step();
      check($sformatf("vec%0d", i), vecs[i].exp_an, vecs[i].exp_d, vecs[i].exp_fd);
    end

    // Load coincident with the frame boundary shows in slot 0 of that frame.
    repeat (3) step();
    load    = 1'b1;
    data_in = 16'h1234;
    step();
    load = 1'b0;
    check("bnd_load_slot0", 4'b1110, 4'h4, 1'b1);

    // Back-to-back loads: the last one wins at the next boundary.
    load    = 1'b1;
    data_in = 16'h1111;
    step();
    data_in = 16'h2222;
    step();
    load = 1'b0;
    repeat (2) step();
    check("b2b_slot1_old", 4'b1101, 4'h3, 1'b0);
    repeat (4) step();
    check("b2b_slot2_old", 4'b1011, 4'h2, 1'b0);
    repeat (4) step();
    check("b2b_slot3_old", 4'b0111, 4'h1, 1'b0);
    repeat (4) step();
    check("b2b_slot0_new", 4'b1110, 4'h2, 1'b1);
    repeat (4) step();
    check("b2b_slot1_new", 4'b1101, 4'h2, 1'b0);
    repeat (4) step();
    check("pre_rst_slot2", 4'b1011, 4'h2, 1'b0);

    // Reset mid-slot must clear outputs before the next clock edge.
    repeat (2) step();
    #2;
    rst = 1'b1;
    #1;
    check("rst_midslot", 4'b1111, 4'h0, 1'b0);
    reset_seq("rst2", 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
